mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-ported unified memory between IF (instruction fetch) and MEM (lw/sw) stages.
//   Grants one requester at a time, registers the transaction, handles a variable-latency memory ack,
//   drives per-stage stalls into pipeline control, and flags hung transactions with a watchdog.
// PARAMETERS
//   ADDR_W          32   address width
//   DATA_W          32   data width
//   TIMEOUT_CYCLES  255  max cycles in a transfer state without mem_ack before abort (1..255)
// PORTS
//   clk          in   1       system clock, all state on rising edge
//   rst          in   1       synchronous, active-high reset
//   if_req       in   1       fetch request, held until if_ack
//   if_addr      in   ADDR_W  fetch address
//   if_rdata     out  DATA_W  fetched instruction, valid while if_ack=1
//   if_ack       out  1       one-cycle completion pulse to IF
//   dm_req       in   1       data request, held until dm_ack
//   dm_we        in   1       1=sw write, 0=lw read
//   dm_addr      in   ADDR_W  data address
//   dm_wdata     in   DATA_W  store data
//   dm_rdata     out  DATA_W  load data, valid while dm_ack=1
//   dm_ack       out  1       one-cycle completion pulse to MEM
//   mem_req      out  1       request to memory, high for whole transfer
//   mem_we       out  1       write strobe to memory
//   mem_addr     out  ADDR_W  latched address
//   mem_wdata    out  DATA_W  latched store data
//   mem_rdata    in   DATA_W  memory read data, valid with mem_ack
//   mem_ack      in   1       memory completion, sampled only while mem_req=1
//   stall_if     out  1       = if_req & ~if_ack (combinational)
//   stall_pipe   out  1       = dm_req & ~dm_ack (combinational); freezes whole pipeline
//   timeout_err  out  1       sticky watchdog flag
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=IF, all acks/mem_req/mem_we/timeout_err=0, rdata regs and latches=0.
//   States: IDLE, IF_XFER, DM_XFER. mem_req = (state!=IDLE); mem_we = (state==DM_XFER) & we_latch.
//   IDLE: eligible_x = x_req & ~x_ack (a requester whose ack is high this cycle is ignored).
//     only DM eligible -> DM_XFER; only IF eligible -> IF_XFER;
//     both -> round-robin: grant DM if last_grant==IF, else IF; last_grant <= granted side.
//     On grant: latch addr (and we/wdata for DM; we_latch=0 for IF); watchdog counter <= 0.
//   XFER: mem_ack=1 at edge -> state IDLE; owner ack<=1 next cycle; on read, owner rdata<=mem_rdata;
//     on write, dm_rdata unchanged. Requester inputs changing mid-transfer have no effect.
//   Latency: req seen in IDLE at edge N -> mem_req high from N; mem_ack at edge N+k -> x_ack high
//     in cycle after N+k. Zero-wait memory (ack at first sampled edge) = 2 cycles req->ack.
//   Acks are single-cycle pulses; never both acks high in the same cycle.
//   Watchdog: counter increments each XFER cycle without mem_ack; reaching TIMEOUT_CYCLES ->
//     abort: state IDLE, owner ack pulse with rdata=0 (write dropped), timeout_err<=1 (cleared only by rst).
//   mem_ack on the same edge as the timeout -> normal completion wins, no error.
//   mem_ack while IDLE: ignored.
//   rst mid-transfer: state IDLE at that edge; mem_req low the following cycle; no ack emitted.
//   Counter width 8 bits; no wrap possible since abort occurs at TIMEOUT_CYCLES.
// STRUCTURE
//   Add to Constants.vh: ARB_IDLE=2'd0, ARB_IF_XFER=2'd1, ARB_DM_XFER=2'd2, ARB_GRANT_IF=1'b0,
//     ARB_GRANT_DM=1'b1.
//   One sub-module: arb_watchdog (clear, enable, 8-bit count, expired output at TIMEOUT_CYCLES).
//   FSM + latches + ack/rdata registers stay in mem_port_arbiter.
// TESTING
//   1 IF-only read, memory acks 3 cycles after mem_req: if_addr=0x0000_0040, mem_rdata=0x2008_0005
//     -> mem_req 3 cycles, if_ack 1 cycle later, if_rdata=0x2008_0005, stall_if low after ack.
//   2 DM write: dm_we=1, addr=0x100, wdata=0xCAFE_F00D, zero-wait ack -> mem_we=1, mem_addr=0x100,
//     mem_wdata=0xCAFE_F00D, dm_ack 2 cycles after dm_req, dm_rdata unchanged.
//   3 Both requests held from reset, 1-wait memory -> grant order DM, IF, DM, IF;
//     acks alternate, never coincident.
//   4 Memory never acks, TIMEOUT_CYCLES=8 -> abort after 8 XFER cycles, owner ack with rdata=0,
//     timeout_err=1 and stays 1 until rst.
//   5 rst asserted for 1 cycle mid DM_XFER -> mem_req low next cycle, no dm_ack, later requests
//     served normally.
//   6 Requester holds req through its ack cycle -> no duplicate grant in that cycle;
//     a new grant is issued only if req still high in the cycle after the ack.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and arbitration helper for the IF/MEM unified-memory port arbiter.
// Imported by the watchdog and the arbiter top.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE    = 2'd0;
    localparam logic [1:0] ARB_IF_XFER = 2'd1;
    localparam logic [1:0] ARB_DM_XFER = 2'd2;

    localparam logic ARB_GRANT_IF = 1'b0;
    localparam logic ARB_GRANT_DM = 1'b1;

    localparam int ARB_CNT_W = 8;

    // With both sides eligible, the side that did not win last time goes next.
    function automatic logic arb_pick(input logic elig_if, input logic elig_dm,
                                      input logic last_grant);
        if (elig_if && elig_dm) begin
            return (last_grant == ARB_GRANT_IF) ? ARB_GRANT_DM : ARB_GRANT_IF;
        end
        return elig_dm ? ARB_GRANT_DM : ARB_GRANT_IF;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              stall_if;
    logic              stall_pipe;
    logic              timeout_err;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_pipe, timeout_err
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ack, dm_rdata, dm_ack, mem_req, mem_we, mem_addr, mem_wdata,
               stall_if, stall_pipe, timeout_err
    );

endinterface

// File: rtl/arb_watchdog.sv
// Transfer watchdog: counts transfer cycles without a memory ack; expired marks the cycle
// whose closing edge completes TIMEOUT_CYCLES of them.
module arb_watchdog
    import mem_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [ARB_CNT_W-1:0] LAST_COUNT = ARB_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [ARB_CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + ARB_CNT_W'(1);
        end
    end

    // Abort fires on the edge that would bring the count to TIMEOUT_CYCLES, so it never wraps.
    assign expired = enable && (count == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the load/store stage,
// one registered transfer at a time, with per-stage stalls and a hung-transfer watchdog.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic              clk,
    input logic              rst,
    mem_port_arbiter_if.slave bus
);

    logic [1:0]        state;
    logic              last_grant;
    logic [ADDR_W-1:0] addr_latch;
    logic [DATA_W-1:0] wdata_latch;
    logic              we_latch;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              timeout_err_q;

    logic elig_if;
    logic elig_dm;
    logic grant_side;
    logic in_xfer;
    logic wd_expired;

    // A requester sitting in its own ack cycle is finishing, not asking again.
    assign elig_if    = bus.if_req & ~if_ack_q;
    assign elig_dm    = bus.dm_req & ~dm_ack_q;
    assign grant_side = arb_pick(elig_if, elig_dm, last_grant);
    assign in_xfer    = (state != ARB_IDLE);

    arb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (~in_xfer),
        .enable (in_xfer & ~bus.mem_ack),
        .expired(wd_expired)
    );

    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ARB_IDLE;
            last_grant    <= ARB_GRANT_IF;
            addr_latch    <= '0;
            wdata_latch   <= '0;
            we_latch      <= 1'b0;
            if_ack_q      <= 1'b0;
            dm_ack_q      <= 1'b0;
            if_rdata_q    <= '0;
            dm_rdata_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if_ack_q <= 1'b0;
            dm_ack_q <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (elig_if || elig_dm) begin
                        last_grant <= grant_side;
                        if (grant_side == ARB_GRANT_DM) begin
                            state       <= ARB_DM_XFER;
                            addr_latch  <= bus.dm_addr;
                            wdata_latch <= bus.dm_wdata;
                            we_latch    <= bus.dm_we;
                        end else begin
                            state      <= ARB_IF_XFER;
                            addr_latch <= bus.if_addr;
                            we_latch   <= 1'b0;
                        end
                    end
                end
                ARB_IF_XFER: begin
                    if (bus.mem_ack) begin
                        state      <= ARB_IDLE;
                        if_ack_q   <= 1'b1;
                        if_rdata_q <= bus.mem_rdata;
                    end else if (wd_expired) begin
                        state         <= ARB_IDLE;
                        if_ack_q      <= 1'b1;
                        if_rdata_q    <= '0;
                        timeout_err_q <= 1'b1;
                    end
                end
                ARB_DM_XFER: begin
                    if (bus.mem_ack) begin
                        state    <= ARB_IDLE;
                        dm_ack_q <= 1'b1;
                        if (!we_latch) begin
                            dm_rdata_q <= bus.mem_rdata;
                        end
                    end else if (wd_expired) begin
                        // Aborted stores are dropped; the stage still gets its ack to unfreeze.
                        state         <= ARB_IDLE;
                        dm_ack_q      <= 1'b1;
                        dm_rdata_q    <= '0;
                        timeout_err_q <= 1'b1;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.mem_req     = in_xfer;
    assign bus.mem_we      = (state == ARB_DM_XFER) & we_latch;
    assign bus.mem_addr    = addr_latch;
    assign bus.mem_wdata   = wdata_latch;
    assign bus.if_ack      = if_ack_q;
    assign bus.dm_ack      = dm_ack_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.dm_rdata    = dm_rdata_q;
    assign bus.timeout_err = timeout_err_q;
    assign bus.stall_if    = bus.if_req & ~if_ack_q;
    assign bus.stall_pipe  = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// all compared against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int HANG    = 1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: who owns the memory, for how long, and what each stage should see.
    bit              m_busy, m_owner_dm, m_we, m_last_dm, m_err, m_if_ack, m_dm_ack;
    int              m_cyc, cur_delay;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata, m_if_rdata, m_dm_rdata;

    // Memory responder knobs: fixed_delay < 0 picks a random wait count per transfer.
    int              fixed_delay  = -1;
    bit              stray_en     = 1'b0;
    bit              rdata_fix_en = 1'b0;
    logic [DATA_W-1:0] rdata_fix  = '0;

    int lat, rc, grants, cyc;
    bit prev_req;
    logic [ADDR_W-1:0] exp_addr;

    function automatic int pick_delay();
        if (fixed_delay >= 0) return fixed_delay;
        case ($urandom_range(0, 31))
            0:       return HANG;
            1, 2:    return TIMEOUT - 1;
            default: return int'($urandom_range(0, 3));
        endcase
    endfunction

    // One clock: drive memory, advance the model, then compare at the falling edge.
    task automatic tick();
        bit elig_if, elig_dm, n_if_ack, n_dm_ack;
        if (m_busy) bus.mem_ack = (m_cyc == cur_delay);
        else        bus.mem_ack = stray_en && ($urandom_range(0, 3) == 0);
        bus.mem_rdata = rdata_fix_en ? rdata_fix : $urandom();
        n_if_ack = 1'b0;
        n_dm_ack = 1'b0;
        if (rst) begin
            m_busy = 1'b0; m_last_dm = 1'b0; m_err = 1'b0;
            m_if_rdata = '0; m_dm_rdata = '0;
        end else if (m_busy) begin
            if (bus.mem_ack || m_cyc == TIMEOUT - 1) begin
                m_busy = 1'b0;
                if (!bus.mem_ack) m_err = 1'b1;
                if (m_owner_dm) begin
                    n_dm_ack = 1'b1;
                    if (!bus.mem_ack) m_dm_rdata = '0;
                    else if (!m_we)   m_dm_rdata = bus.mem_rdata;
                end else begin
                    n_if_ack   = 1'b1;
                    m_if_rdata = bus.mem_ack ? bus.mem_rdata : '0;
                end
            end else begin
                m_cyc++;
            end
        end else begin
            elig_if = bus.if_req && !m_if_ack;
            elig_dm = bus.dm_req && !m_dm_ack;
            if (elig_if || elig_dm) begin
                m_owner_dm = elig_dm && (!elig_if || !m_last_dm);
                m_last_dm  = m_owner_dm;
                m_busy     = 1'b1;
                m_cyc      = 0;
                cur_delay  = pick_delay();
                m_addr     = m_owner_dm ? bus.dm_addr : bus.if_addr;
                m_we       = m_owner_dm && bus.dm_we;
                if (m_owner_dm) m_wdata = bus.dm_wdata;
            end
        end
        m_if_ack = n_if_ack;
        m_dm_ack = n_dm_ack;
        @(posedge clk);
        @(negedge clk);
        check("mem_req", 64'(bus.mem_req), 64'(m_busy));
        check("mem_we", 64'(bus.mem_we), 64'(m_busy && m_we));
        if (m_busy) check("mem_addr", 64'(bus.mem_addr), 64'(m_addr));
        if (m_busy && m_we) check("mem_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        check("if_ack", 64'(bus.if_ack), 64'(m_if_ack));
        check("dm_ack", 64'(bus.dm_ack), 64'(m_dm_ack));
        if (m_if_ack) check("if_rdata", 64'(bus.if_rdata), 64'(m_if_rdata));
        if (m_dm_ack) check("dm_rdata", 64'(bus.dm_rdata), 64'(m_dm_rdata));
        check("timeout_err", 64'(bus.timeout_err), 64'(m_err));
        check("stall_if", 64'(bus.stall_if), 64'(bus.if_req && !m_if_ack));
        check("stall_pipe", 64'(bus.stall_pipe), 64'(bus.dm_req && !m_dm_ack));
    endtask

    // Clock until the chosen stage's ack shows up, bounded by budget.
    task automatic wait_ack(input bit dm, input int budget, output int n_lat, output int n_req);
        bit seen = 1'b0;
        n_lat = 0;
        n_req = 0;
        while (!seen && n_lat < budget) begin
            tick();
            n_lat++;
            if (bus.mem_req) n_req++;
            seen = dm ? bus.dm_ack : bus.if_ack;
        end
        if (!seen) begin
            if (dm) check("dm_ack_wait", 64'(bus.dm_ack), 64'(1));
            else    check("if_ack_wait", 64'(bus.if_ack), 64'(1));
        end
    endtask

    task automatic agents();
        if (!bus.if_req || m_if_ack) begin
            bus.if_req  = (bus.if_req && m_if_ack) ? ($urandom_range(0, 1) == 1)
                                                   : ($urandom_range(0, 2) == 0);
            bus.if_addr = $urandom();
        end else if ($urandom_range(0, 3) == 0) begin
            bus.if_addr = $urandom();
        end
        if (!bus.dm_req || m_dm_ack) begin
            bus.dm_req   = (bus.dm_req && m_dm_ack) ? ($urandom_range(0, 1) == 1)
                                                    : ($urandom_range(0, 2) == 0);
            bus.dm_we    = $urandom_range(0, 1) == 1;
            bus.dm_addr  = $urandom();
            bus.dm_wdata = $urandom();
        end else if ($urandom_range(0, 3) == 0) begin
            bus.dm_we    = $urandom_range(0, 1) == 1;
            bus.dm_addr  = $urandom();
            bus.dm_wdata = $urandom();
        end
        rst = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        rst          = 1'b1;
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.dm_req   = 1'b0;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.mem_ack  = 1'b0;
        bus.mem_rdata = '0;
        @(negedge clk);
        tick();
        tick();
        check("rst_if_rdata", 64'(bus.if_rdata), 64'(0));
        check("rst_dm_rdata", 64'(bus.dm_rdata), 64'(0));
        check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'(0));
        rst = 1'b0;

        // IF-only read, memory acks in the third mem_req cycle.
        fixed_delay  = 2;
        rdata_fix_en = 1'b1;
        rdata_fix    = 32'h2008_0005;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_0040;
        wait_ack(1'b0, 20, lat, rc);
        check("t1_if_rdata", 64'(bus.if_rdata), 64'h2008_0005);
        check("t1_mem_req_cycles", 64'(rc), 64'(3));
        check("t1_req_to_ack", 64'(lat), 64'(4));
        bus.if_req   = 1'b0;
        rdata_fix_en = 1'b0;
        tick();
        check("t1_stall_if_low", 64'(bus.stall_if), 64'(0));

        // Zero-wait store.
        fixed_delay  = 0;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0100;
        bus.dm_wdata = 32'hCAFE_F00D;
        tick();
        check("t2_mem_we", 64'(bus.mem_we), 64'(1));
        check("t2_mem_addr", 64'(bus.mem_addr), 64'h100);
        check("t2_mem_wdata", 64'(bus.mem_wdata), 64'hCAFE_F00D);
        wait_ack(1'b1, 20, lat, rc);
        check("t2_req_to_ack", 64'(lat + 1), 64'(2));
        check("t2_dm_rdata_kept", 64'(bus.dm_rdata), 64'(0));
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        tick();

        // Both requests held from reset, one-wait memory: strict alternation starting with DM.
        rst          = 1'b1;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h0000_1000;
        bus.dm_req   = 1'b1;
        bus.dm_addr  = 32'h0000_2000;
        tick();
        rst          = 1'b0;
        fixed_delay  = 1;
        grants       = 0;
        cyc          = 0;
        prev_req     = 1'b0;
        while (grants < 4 && cyc < 60) begin
            tick();
            cyc++;
            check("t3_acks_exclusive", 64'(bus.if_ack & bus.dm_ack), 64'(0));
            if (bus.mem_req && !prev_req) begin
                exp_addr = (grants % 2 == 0) ? 32'h0000_2000 : 32'h0000_1000;
                check("t3_grant_order", 64'(bus.mem_addr), 64'(exp_addr));
                grants++;
            end
            prev_req = bus.mem_req;
        end
        if (grants < 4) check("t3_grant_count", 64'(grants), 64'(4));
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (6) tick();

        // Ack on the same edge as the timeout: normal completion, no error.
        fixed_delay = TIMEOUT - 1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0044;
        wait_ack(1'b0, 30, lat, rc);
        check("t4a_mem_req_cycles", 64'(rc), 64'(TIMEOUT));
        check("t4a_no_error", 64'(bus.timeout_err), 64'(0));
        bus.if_req = 1'b0;
        tick();

        // Memory never answers: abort after TIMEOUT transfer cycles.
        fixed_delay = HANG;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h0000_0300;
        wait_ack(1'b1, 30, lat, rc);
        check("t4_mem_req_cycles", 64'(rc), 64'(TIMEOUT));
        check("t4_req_to_ack", 64'(lat), 64'(TIMEOUT + 1));
        check("t4_dm_rdata_zero", 64'(bus.dm_rdata), 64'(0));
        check("t4_timeout_err", 64'(bus.timeout_err), 64'(1));
        bus.dm_req  = 1'b0;
        fixed_delay = 0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0048;
        wait_ack(1'b0, 10, lat, rc);
        bus.if_req = 1'b0;
        tick();
        check("t4_err_sticky", 64'(bus.timeout_err), 64'(1));

        // Reset in the middle of a store transfer.
        fixed_delay  = HANG;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h0000_0500;
        bus.dm_wdata = 32'h1234_5678;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_mem_req_low", 64'(bus.mem_req), 64'(0));
        check("t5_no_dm_ack", 64'(bus.dm_ack), 64'(0));
        check("t5_err_cleared", 64'(bus.timeout_err), 64'(0));
        fixed_delay = 0;
        wait_ack(1'b1, 10, lat, rc);
        check("t5_served_after_rst", 64'(lat), 64'(2));
        bus.dm_req = 1'b0;
        bus.dm_we  = 1'b0;
        tick();

        // Request held through its own ack: no grant in the ack cycle, regrant right after.
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0060;
        wait_ack(1'b0, 10, lat, rc);
        tick();
        check("t6_no_regrant_in_ack", 64'(bus.mem_req), 64'(0));
        tick();
        check("t6_regrant_after_ack", 64'(bus.mem_req), 64'(1));
        bus.if_req = 1'b0;
        repeat (4) tick();

        // Randomized traffic with random waits, hangs, stray acks and occasional resets.
        fixed_delay = -1;
        stray_en    = 1'b1;
        repeat (1500) begin
            agents();
            tick();
        end
        rst        = 1'b0;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (12) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
